// File: rtl/datagram_receiver.sv
// rtl/datagram_receiver.sv - sync-byte framed datagram receiver, committed on display frame_sync.
// Optional XOR checksum byte after the payload: define DATAGRAM_CHECKSUM_EN.
module datagram_receiver #(
   parameter int          MSG_WIDTH      = 256,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_byte,
   input  logic                 rx_valid,
   input  logic                 frame_sync,
   output logic [MSG_WIDTH-1:0] datagram,
   output logic                 datagram_valid,
   output logic                 commit,
   output logic                 frame_err
);

   localparam int NBYTES = (MSG_WIDTH + 7) / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1
`ifdef DATAGRAM_CHECKSUM_EN
      , CHECK = 2'd2
`endif
   } state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [GAP_W-1:0]       gap;
   logic [NBYTES*8-1:0]    asm_buf;
   logic [MSG_WIDTH-1:0]   pend_buf;
   logic                   pending;
   logic                   accept_q;
`ifdef DATAGRAM_CHECKSUM_EN
   logic [7:0]             csum;
`endif

   // Current idle cycle is the TIMEOUT_CYCLES-th since the last byte of an open frame.
   logic timeout;
   assign timeout = (state != HUNT) && !rx_valid && (gap >= GAP_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= HUNT;
         idx            <= '0;
         gap            <= '0;
         asm_buf        <= '0;
         pend_buf       <= '0;
         pending        <= 1'b0;
         accept_q       <= 1'b0;
         datagram       <= '0;
         datagram_valid <= 1'b0;
         commit         <= 1'b0;
         frame_err      <= 1'b0;
`ifdef DATAGRAM_CHECKSUM_EN
         csum           <= 8'h00;
`endif
      end else begin
         commit    <= 1'b0;
         frame_err <= 1'b0;
         accept_q  <= 1'b0;

         // Only a frame pending before this edge may commit; a same-cycle acceptance waits.
         if (frame_sync && pending) begin
            datagram       <= pend_buf;
            datagram_valid <= 1'b1;
            commit         <= 1'b1;
            pending        <= 1'b0;
         end
         if (accept_q) begin
            pend_buf <= asm_buf[MSG_WIDTH-1:0];
            pending  <= 1'b1;
         end

         if (timeout) begin
            state     <= HUNT;
            idx       <= '0;
            gap       <= '0;
            frame_err <= 1'b1;
         end else begin
            if (rx_valid || state == HUNT)
               gap <= '0;
            else if (gap != GAP_SAT)
               gap <= gap + 1'b1;

            case (state)
               HUNT: begin
                  idx <= '0;
                  if (rx_valid && rx_byte == SYNC_BYTE)
                     state <= PAYLOAD;
               end
               PAYLOAD: begin
                  if (rx_valid) begin
                     asm_buf[idx*8 +: 8] <= rx_byte;
`ifdef DATAGRAM_CHECKSUM_EN
                     csum <= (idx == '0) ? rx_byte : (csum ^ rx_byte);
`endif
                     if (idx == LAST_IDX) begin
                        idx <= '0;
`ifdef DATAGRAM_CHECKSUM_EN
                        state <= CHECK;
`else
                        state    <= HUNT;
                        accept_q <= 1'b1;
`endif
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
`ifdef DATAGRAM_CHECKSUM_EN
               CHECK: begin
                  if (rx_valid) begin
                     state <= HUNT;
                     if (rx_byte == csum)
                        accept_q <= 1'b1;
                     else
                        frame_err <= 1'b1;
                  end
               end
`endif
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule
